// File: rtl/m2_pkg.sv
// Shared Milestone 2 types: arbiter state, read-return tag, SRAM bus widths.
package m2_pkg;

  localparam int unsigned M2_SRAM_AW = 18;
  localparam int unsigned M2_SRAM_DW = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1
  } m2_arb_state_type;

  typedef struct packed {
    logic valid;
    logic id;
  } m2_rd_tag_t;

endpackage

// File: rtl/m2_rd_tag_pipe.sv
// Read-tag delay line: a read tag pushed at accept emerges RD_LATENCY+1 cycles later
// as a one-hot rvalid, lined up with the SRAM read data.
module m2_rd_tag_pipe
  import m2_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  m2_rd_tag_t push,
  output logic [1:0] rvalid,
  output logic       busy
);

  localparam int unsigned PW = RD_LATENCY * $bits(m2_rd_tag_t);

  m2_rd_tag_t [RD_LATENCY-1:0] pipe;
  m2_rd_tag_t [RD_LATENCY-1:0] pipe_nxt;
  logic       [RD_LATENCY-1:0] vmask;
  m2_rd_tag_t                  tail;

  // Shift toward the tail; the oldest entry drops off the top.
  always_comb begin
    pipe_nxt = PW'({pipe, push});
    tail     = pipe[RD_LATENCY-1];
  end

  for (genvar k = 0; k < RD_LATENCY; k++) begin : g_vmask
    assign vmask[k] = pipe_nxt[k].valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe   <= '0;
      rvalid <= 2'b00;
      busy   <= 1'b0;
    end else begin
      pipe   <= pipe_nxt;
      rvalid <= {tail.valid & tail.id, tail.valid & ~tail.id};
      busy   <= |vmask;
    end
  end

endmodule

// File: rtl/m2_sram_arbiter.sv
// Round-robin SRAM port arbiter for M2 fetch (0) and write-back (1) with burst hold.
// Define M2_ARB_STATS_EN to build the per-requester beat/stall counters.
module m2_sram_arbiter
  import m2_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                       CLOCK_50_I,
  input  logic                       Reset,
  input  logic [1:0]                 req,
  input  logic [1:0]                 req_we_n,
  input  logic [1:0][M2_SRAM_AW-1:0] req_address,
  input  logic [1:0][M2_SRAM_DW-1:0] req_write_data,
  output logic [1:0]                 gnt,
  output logic [1:0]                 rvalid,
  output logic [M2_SRAM_DW-1:0]      read_data,
  output logic [M2_SRAM_AW-1:0]      SRAM_address,
  output logic [M2_SRAM_DW-1:0]      SRAM_write_data,
  output logic                       SRAM_we_n,
  input  logic [M2_SRAM_DW-1:0]      SRAM_read_data,
  output logic                       busy,
  output logic [15:0]                stat_beats0,
  output logic [15:0]                stat_beats1,
  output logic [15:0]                stat_stall0,
  output logic [15:0]                stat_stall1
);

  localparam int unsigned CNT_W = 4;

  m2_arb_state_type state;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_owner;
  logic             owner;
  logic             owned;
  logic             expired;
  logic             acc;
  logic             acc_id;
  m2_rd_tag_t       push;

  assign read_data = SRAM_read_data;

  // Grant: owner keeps the port until its burst expires under contention.
  always_comb begin
    gnt     = 2'b00;
    owned   = (state != ARB_IDLE);
    owner   = (state == ARB_OWN1);
    expired = (burst_cnt == CNT_W'(MAX_BURST));
    if (!Reset) begin
      if (owned && req[owner]) begin
        if (expired && req[~owner]) gnt[~owner] = 1'b1;
        else                        gnt[owner]  = 1'b1;
      end else if (req == 2'b11) begin
        gnt[~last_owner] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_comb begin
    acc        = |(req & gnt);
    acc_id     = gnt[1];
    push.valid = acc & req_we_n[acc_id];
    push.id    = acc_id;
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state           <= ARB_IDLE;
      burst_cnt       <= '0;
      last_owner      <= 1'b1;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
    end else if (acc) begin
      state      <= acc_id ? ARB_OWN1 : ARB_OWN0;
      last_owner <= acc_id;
      if (owned && owner == acc_id) begin
        burst_cnt <= expired ? burst_cnt : burst_cnt + CNT_W'(1);
      end else begin
        burst_cnt <= CNT_W'(1);
      end
      SRAM_address    <= req_address[acc_id];
      SRAM_write_data <= req_write_data[acc_id];
      SRAM_we_n       <= req_we_n[acc_id];
    end else begin
      SRAM_we_n <= 1'b1;
      if (req == 2'b00) begin
        state     <= ARB_IDLE;
        burst_cnt <= '0;
      end
    end
  end

  m2_rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk   (CLOCK_50_I),
    .reset (Reset),
    .push  (push),
    .rvalid(rvalid),
    .busy  (busy)
  );

`ifdef M2_ARB_STATS_EN
  logic [1:0][15:0] beats;
  logic [1:0][15:0] stall;

  // Saturating per-requester accepted-beat and stalled-cycle counters.
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      beats <= '0;
      stall <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req[i] && gnt[i] && beats[i] != 16'hFFFF) beats[i] <= beats[i] + 16'd1;
        if (req[i] && !gnt[i] && stall[i] != 16'hFFFF) stall[i] <= stall[i] + 16'd1;
      end
    end
  end

  assign stat_beats0 = beats[0];
  assign stat_beats1 = beats[1];
  assign stat_stall0 = stall[0];
  assign stat_stall1 = stall[1];
`else
  assign stat_beats0 = 16'd0;
  assign stat_beats1 = 16'd0;
  assign stat_stall0 = 16'd0;
  assign stat_stall1 = 16'd0;
`endif

endmodule

// File: tb/tb_m2_sram_arbiter.sv
// Directed bench for m2_sram_arbiter: reset, burst rotation, read/write overlap,
// owner drop, reset with reads in flight, and the stats ports.
module tb_m2_sram_arbiter;

  logic              clk = 1'b0;
  logic              Reset;
  logic [1:0]        req;
  logic [1:0]        req_we_n;
  logic [1:0][17:0]  req_address;
  logic [1:0][15:0]  req_write_data;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [15:0]       read_data;
  logic [17:0]       SRAM_address;
  logic [15:0]       SRAM_write_data;
  logic              SRAM_we_n;
  logic [15:0]       SRAM_read_data;
  logic              busy;
  logic [15:0]       stat_beats0, stat_beats1, stat_stall0, stat_stall1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  localparam logic [17:0] A0 = 18'h00AAA;
  localparam logic [17:0] A1 = 18'h15555;

  m2_sram_arbiter dut (
    .CLOCK_50_I     (clk),
    .Reset          (Reset),
    .req            (req),
    .req_we_n       (req_we_n),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .read_data      (read_data),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (SRAM_read_data),
    .busy           (busy),
    .stat_beats0    (stat_beats0),
    .stat_beats1    (stat_beats1),
    .stat_stall0    (stat_stall0),
    .stat_stall1    (stat_stall1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected grant during continuous contention with MAX_BURST = 8.
  function automatic logic [1:0] exp_gnt(input int c);
    return ((c / 8) % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    Reset          = 1'b1;
    req            = 2'b11;
    req_we_n       = 2'b11;
    req_address[0] = A0;
    req_address[1] = A1;
    req_write_data = '0;
    SRAM_read_data = 16'h1234;

    // Reset held with both requesting
    tick(); tick();
    @(negedge clk);
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst we_n", 32'(SRAM_we_n), 32'h1);
    check("rst addr", 32'(SRAM_address), 32'h0);
    check("rst wdata", 32'(SRAM_write_data), 32'h0);
    check("rst rvalid", 32'(rvalid), 32'h0);
    check("rst busy", 32'(busy), 32'h0);

    // Continuous contention: 8 beats each, alternating, all reads
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      check($sformatf("burst gnt c%0d", c), 32'(gnt), 32'(exp_gnt(c)));
      check($sformatf("burst we_n c%0d", c), 32'(SRAM_we_n), 32'h1);
      if (c >= 1)
        check($sformatf("burst addr c%0d", c), 32'(SRAM_address),
              32'((exp_gnt(c - 1) == 2'b01) ? A0 : A1));
      check($sformatf("burst rvalid c%0d", c), 32'(rvalid),
            32'((c >= 3) ? exp_gnt(c - 3) : 2'b00));
    end

    // Stats: reset, then 20 cycles of contention, then release
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    tick();
    req = 2'b00;
    @(negedge clk);
    check("idle gnt", 32'(gnt), 32'h0);
`ifdef M2_ARB_STATS_EN
    check("stat beats0", 32'(stat_beats0), 32'd12);
    check("stat beats1", 32'(stat_beats1), 32'd8);
    check("stat beats sum", 32'(stat_beats0) + 32'(stat_beats1), 32'd20);
    check("stat stall0", 32'(stat_stall0), 32'd8);
    check("stat stall1", 32'(stat_stall1), 32'd12);
`else
    check("stat beats0 tied", 32'(stat_beats0), 32'd0);
    check("stat beats1 tied", 32'(stat_beats1), 32'd0);
    check("stat stall0 tied", 32'(stat_stall0), 32'd0);
    check("stat stall1 tied", 32'(stat_stall1), 32'd0);
`endif

    // Read by 0 then write by 1 back-to-back
    tick();
    req            = 2'b01;
    req_we_n       = 2'b11;
    req_address[0] = 18'h00010;
    @(negedge clk);
    check("ovl gnt rd", 32'(gnt), 32'h1);
    tick();
    req               = 2'b10;
    req_we_n          = 2'b01;
    req_address[1]    = 18'h3F000;
    req_write_data[1] = 16'hBEEF;
    @(negedge clk);
    check("ovl gnt wr", 32'(gnt), 32'h2);
    check("ovl addr rd", 32'(SRAM_address), 32'h00010);
    check("ovl we_n rd", 32'(SRAM_we_n), 32'h1);
    tick();
    req      = 2'b00;
    req_we_n = 2'b11;
    @(negedge clk);
    check("ovl addr wr", 32'(SRAM_address), 32'h3F000);
    check("ovl wdata", 32'(SRAM_write_data), 32'hBEEF);
    check("ovl we_n wr", 32'(SRAM_we_n), 32'h0);
    check("ovl rvalid early", 32'(rvalid), 32'h0);
    check("ovl busy", 32'(busy), 32'h1);
    tick();
    @(negedge clk);
    check("ovl rvalid", 32'(rvalid), 32'h1);
    check("ovl read_data", 32'(read_data), 32'h1234);
    check("ovl we_n idle", 32'(SRAM_we_n), 32'h1);
    check("ovl addr hold", 32'(SRAM_address), 32'h3F000);
    tick();
    @(negedge clk);
    check("ovl rvalid done", 32'(rvalid), 32'h0);
    check("ovl busy done", 32'(busy), 32'h0);

    // Requester 1 owns for 3 beats with 0 waiting, then drops
    tick();
    req = 2'b10;
    @(negedge clk);
    check("drop gnt b0", 32'(gnt), 32'h2);
    tick();
    req = 2'b11;
    @(negedge clk);
    check("drop gnt b1", 32'(gnt), 32'h2);
    tick();
    @(negedge clk);
    check("drop gnt b2", 32'(gnt), 32'h2);
    tick();
    req = 2'b01;
    @(negedge clk);
    check("drop gnt b3", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;

    // Two reads in flight when reset pulses
    tick();
    req            = 2'b01;
    req_address[0] = 18'h00020;
    tick();
    @(negedge clk);
    check("flush earlier rvalid", 32'(rvalid), 32'h1);
    tick();
    req   = 2'b00;
    Reset = 1'b1;
    @(negedge clk);
    check("flush busy pre", 32'(busy), 32'h1);
    check("flush gnt in reset", 32'(gnt), 32'h0);
    tick();
    Reset = 1'b0;
    @(negedge clk);
    check("flush busy post", 32'(busy), 32'h0);
    check("flush rvalid c3", 32'(rvalid), 32'h0);
    check("flush addr", 32'(SRAM_address), 32'h0);
    check("flush we_n", 32'(SRAM_we_n), 32'h1);
    tick();
    @(negedge clk);
    check("flush rvalid c4", 32'(rvalid), 32'h0);
    tick();
    @(negedge clk);
    check("flush rvalid c5", 32'(rvalid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
